fifo_fill_ctrl: RTL and testbench

- Miss/fill sequencer for the 2-way, 8-set cache.
- Tracks per-set valid bits and a per-set FIFO replacement pointer.
- On each CPU lookup, either acknowledges a hit or runs a miss sequence: pick victim, request the line from memory, write it into the chosen way, advance the FIFO pointer.
- Sits between the tag-compare logic and the memory-side request/response interface.

---
 rtl/fifo_fill_ctrl_pkg.sv | 28 ++
 rtl/fifo_repl_state.sv | 53 +++++
 rtl/fifo_fill_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fifo_fill_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_fill_ctrl_pkg.sv
// Shared types and helpers for the fifo_fill_ctrl miss/fill sequencer.
package fifo_fill_ctrl_pkg;

    localparam int WAYS      = 2;
    localparam int SETS_DEF  = 8;
    localparam int IDX_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        DONE
    } state_t;

    // Prefer an empty way; only when the set is full fall back to the FIFO pointer.
    function automatic logic pick_victim(input logic [WAYS-1:0] valid, input logic ptr);
        if (!valid[0]) begin
            return 1'b0;
        end else if (!valid[1]) begin
            return 1'b1;
        end else begin
            return ptr;
        end
    endfunction

endpackage

// File: rtl/fifo_repl_state.sv
// Per-set valid bits and FIFO replacement pointer for the 2-way cache.
// Combinational read port (used by the same-cycle hit check), single update port.
module fifo_repl_state
    import fifo_fill_ctrl_pkg::*;
#(
    parameter int SETS  = SETS_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    output logic [WAYS-1:0]  rd_valid,
    output logic             rd_ptr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_way
);

    logic [WAYS-1:0] valid_reg [SETS];
    logic [SETS-1:0] ptr_reg;
    logic [SETS-1:0] set_sel;

    // One-hot decode of the set being filled.
    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_sel
            assign set_sel[gi] = upd_en && (upd_index == IDX_W'(gi));
        end
    endgenerate

    assign rd_valid = valid_reg[rd_index];
    assign rd_ptr   = ptr_reg[rd_index];

    // Mark the filled way valid; the pointer only moves when a valid line was displaced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
            end
            ptr_reg <= '0;
        end else begin
            for (int s = 0; s < SETS; s++) begin
                if (set_sel[s]) begin
                    valid_reg[s][upd_way] <= 1'b1;
                    if (&valid_reg[s]) begin
                        ptr_reg[s] <= ~upd_way;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fifo_fill_ctrl.sv
// Miss/fill sequencer for the 2-way set-associative cache with FIFO replacement.
// Optional statistics counters (hit/miss/evict) are built when FIFO_FILL_STATS_EN is defined.
module fifo_fill_ctrl
    import fifo_fill_ctrl_pkg::*;
#(
    parameter int SETS  = SETS_DEF,
    parameter int IDX_W = IDX_W_DEF
`ifdef FIFO_FILL_STATS_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req_valid,
    input  logic [IDX_W-1:0] cpu_index,
    input  logic             hit_way0,
    input  logic             hit_way1,
    output logic             cpu_ready,
    output logic             cpu_done,
    output logic             cpu_hit,
    output logic             cpu_way,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [IDX_W-1:0] mem_req_index,
    input  logic             mem_rsp_valid,
    output logic             fill_we,
    output logic             fill_way,
`ifdef FIFO_FILL_STATS_EN
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] evict_cnt,
`endif
    output logic [IDX_W-1:0] fill_index
);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             victim_reg, victim_next;
    logic             hit_done_reg, hit_done_next;
    logic             hit_way_reg, hit_way_next;

    logic [IDX_W-1:0] rd_index;
    logic [WAYS-1:0]  rd_valid;
    logic             rd_ptr;
    logic             hit0, hit1;
    logic             req_take;

    // While idle the lookup index addresses the tables; afterwards the latched miss index does.
    assign rd_index = (state_reg == IDLE) ? cpu_index : idx_reg;
    assign hit0     = hit_way0 && rd_valid[0];
    assign hit1     = hit_way1 && rd_valid[1];
    assign req_take = (state_reg == IDLE) && !hit_done_reg && cpu_req_valid;

    assign mem_req_index = idx_reg;
    assign fill_way      = victim_reg;
    assign fill_index    = idx_reg;

    fifo_repl_state #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_repl (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (rd_index),
        .rd_valid  (rd_valid),
        .rd_ptr    (rd_ptr),
        .upd_en    (state_reg == FILL),
        .upd_index (idx_reg),
        .upd_way   (victim_reg)
    );

    // State and latched request context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            victim_reg   <= 1'b0;
            hit_done_reg <= 1'b0;
            hit_way_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            victim_reg   <= victim_next;
            hit_done_reg <= hit_done_next;
            hit_way_reg  <= hit_way_next;
        end
    end

    // Next-state and output decode; a hit completes in the cycle after the lookup without leaving IDLE.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        victim_next   = victim_reg;
        hit_done_next = 1'b0;
        hit_way_next  = hit_way_reg;
        cpu_ready     = 1'b0;
        cpu_done      = 1'b0;
        cpu_hit       = 1'b0;
        cpu_way       = 1'b0;
        mem_req_valid = 1'b0;
        fill_we       = 1'b0;
        case (state_reg)
            IDLE: begin
                cpu_ready = !hit_done_reg;
                if (hit_done_reg) begin
                    cpu_done = 1'b1;
                    cpu_hit  = 1'b1;
                    cpu_way  = hit_way_reg;
                end
                if (req_take) begin
                    if (hit0 || hit1) begin
                        hit_done_next = 1'b1;
                        hit_way_next  = !hit0;
                    end else begin
                        idx_next    = cpu_index;
                        victim_next = pick_victim(rd_valid, rd_ptr);
                        state_next  = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                fill_we    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                cpu_done   = 1'b1;
                cpu_way    = victim_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef FIFO_FILL_STATS_EN
    logic [CNT_W-1:0] hit_cnt_reg, miss_cnt_reg, evict_cnt_reg;
    logic             evict_now;

    // A fill evicts only when the chosen way already held a line.
    assign evict_now = (state_reg == FILL) && rd_valid[victim_reg];

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            evict_cnt_reg <= '0;
        end else begin
            if (cpu_done && cpu_hit && !(&hit_cnt_reg)) begin
                hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
            end
            if (cpu_done && !cpu_hit && !(&miss_cnt_reg)) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            end
            if (evict_now && !(&evict_cnt_reg)) begin
                evict_cnt_reg <= evict_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign hit_cnt   = hit_cnt_reg;
    assign miss_cnt  = miss_cnt_reg;
    assign evict_cnt = evict_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl: directed scenarios plus random traffic
// compared against a set/way/FIFO model of the cache bookkeeping.
module tb_fifo_fill_ctrl;

    localparam int SETS  = 8;
    localparam int IDX_W = 3;
`ifdef FIFO_FILL_STATS_EN
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cpu_req_valid = 1'b0;
    logic [IDX_W-1:0] cpu_index = '0;
    logic             hit_way0 = 1'b0;
    logic             hit_way1 = 1'b0;
    logic             mem_req_ready = 1'b0;
    logic             mem_rsp_valid = 1'b0;
    logic             cpu_ready, cpu_done, cpu_hit, cpu_way;
    logic             mem_req_valid, fill_we, fill_way;
    logic [IDX_W-1:0] mem_req_index, fill_index;
`ifdef FIFO_FILL_STATS_EN
    logic [CNT_W-1:0] hit_cnt, miss_cnt, evict_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: which lines hold data and which way goes next when a set is full.
    bit m_valid [SETS][2];
    bit m_ptr   [SETS];
    int m_hits, m_misses, m_evicts;

    fifo_fill_ctrl #(
        .SETS  (SETS),
`ifdef FIFO_FILL_STATS_EN
        .CNT_W (CNT_W),
`endif
        .IDX_W (IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req_valid (cpu_req_valid),
        .cpu_index     (cpu_index),
        .hit_way0      (hit_way0),
        .hit_way1      (hit_way1),
        .cpu_ready     (cpu_ready),
        .cpu_done      (cpu_done),
        .cpu_hit       (cpu_hit),
        .cpu_way       (cpu_way),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_index (mem_req_index),
        .mem_rsp_valid (mem_rsp_valid),
        .fill_we       (fill_we),
        .fill_way      (fill_way),
`ifdef FIFO_FILL_STATS_EN
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
        .evict_cnt     (evict_cnt),
`endif
        .fill_index    (fill_index)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_ptr[s]      = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
        m_evicts = 0;
    endtask

    // One CPU lookup from request to completion, with memory stalls and stray inputs.
    task automatic run_txn(input int idx, input bit h0, input bit h1, input int req_wait, input int rsp_wait);
        bit exp_hit, exp_way, was_full, done;
        int exp_lat, cyc, nreq, nwait, nfill, phase, got_lat;
        exp_hit  = (h0 && m_valid[idx][0]) || (h1 && m_valid[idx][1]);
        was_full = m_valid[idx][0] && m_valid[idx][1];
        if (exp_hit) begin
            exp_way = !(h0 && m_valid[idx][0]);
            exp_lat = 1;
        end else begin
            if (!m_valid[idx][0])      exp_way = 1'b0;
            else if (!m_valid[idx][1]) exp_way = 1'b1;
            else                       exp_way = m_ptr[idx];
            exp_lat = 4 + req_wait + rsp_wait;
        end

        vectors++;
        if (cpu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_req idx=%0d got=%b want=1", idx, cpu_ready);
        end

        cpu_req_valid = 1'b1;
        cpu_index     = IDX_W'(idx);
        hit_way0      = h0;
        hit_way1      = h1;
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_rsp_valid = 1'($urandom_range(0, 1));
        cyc = 0; nreq = 0; nwait = 0; nfill = 0; phase = 0; done = 1'b0; got_lat = 0;

        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            vectors++;
            if (cpu_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_ready idx=%0d cyc=%0d got=%b want=0", idx, cyc, cpu_ready);
            end
            if (fill_we === 1'b1) begin
                nfill++;
                vectors++;
                if (fill_way !== exp_way || fill_index !== IDX_W'(idx)) begin
                    miscompares++;
                    $display("FAIL fill_target idx=%0d got way=%b index=%0d want way=%b index=%0d",
                             idx, fill_way, fill_index, exp_way, idx);
                end
            end
            if (cpu_done === 1'b1) begin
                done    = 1'b1;
                got_lat = cyc;
                vectors++;
                if (cyc != exp_lat || cpu_hit !== exp_hit || cpu_way !== exp_way) begin
                    miscompares++;
                    $display("FAIL completion idx=%0d got lat=%0d hit=%b way=%b want lat=%0d hit=%b way=%b",
                             idx, cyc, cpu_hit, cpu_way, exp_lat, exp_hit, exp_way);
                end
            end
            // Requester side: hold nothing once accepted; scatter ignored requests while busy on a miss.
            if (!done && !exp_hit) begin
                cpu_req_valid = 1'($urandom_range(0, 1));
                cpu_index     = IDX_W'($urandom_range(0, SETS - 1));
                hit_way0      = 1'($urandom_range(0, 1));
                hit_way1      = 1'($urandom_range(0, 1));
            end else begin
                cpu_req_valid = 1'b0;
                hit_way0      = 1'b0;
                hit_way1      = 1'b0;
            end
            // Memory side.
            if (mem_req_valid === 1'b1) begin
                nreq++;
                vectors++;
                if (mem_req_index !== IDX_W'(idx)) begin
                    miscompares++;
                    $display("FAIL req_index idx=%0d got=%0d want=%0d", idx, mem_req_index, idx);
                end
                mem_req_ready = (nreq > req_wait);
                if (mem_req_ready) phase = 1;
                mem_rsp_valid = 1'($urandom_range(0, 1));
            end else if (phase == 1) begin
                nwait++;
                mem_req_ready = 1'($urandom_range(0, 1));
                mem_rsp_valid = (nwait > rsp_wait);
                if (mem_rsp_valid) phase = 2;
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
                mem_rsp_valid = 1'($urandom_range(0, 1));
            end
        end

        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout idx=%0d got no cpu_done in %0d cycles want cpu_done", idx, cyc);
        end
        vectors++;
        if (nreq != (exp_hit ? 0 : req_wait + 1) || nfill != (exp_hit ? 0 : 1)) begin
            miscompares++;
            $display("FAIL mem_handshake idx=%0d got req_cycles=%0d fills=%0d want req_cycles=%0d fills=%0d",
                     idx, nreq, nfill, exp_hit ? 0 : req_wait + 1, exp_hit ? 0 : 1);
        end

        // Update the model from the rules, not from the DUT.
        if (exp_hit) begin
            m_hits++;
        end else begin
            if (was_full) begin
                m_evicts++;
                m_ptr[idx] = !exp_way;
            end
            m_valid[idx][exp_way] = 1'b1;
            m_misses++;
        end

        cpu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (cpu_done !== 1'b0 || cpu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_done idx=%0d got done=%b ready=%b want done=0 ready=1", idx, cpu_done, cpu_ready);
        end
`ifdef FIFO_FILL_STATS_EN
        vectors++;
        if (hit_cnt !== CNT_W'(m_hits > CNT_MAX ? CNT_MAX : m_hits) ||
            miss_cnt !== CNT_W'(m_misses > CNT_MAX ? CNT_MAX : m_misses) ||
            evict_cnt !== CNT_W'(m_evicts > CNT_MAX ? CNT_MAX : m_evicts)) begin
            miscompares++;
            $display("FAIL stats got hit=%0d miss=%0d evict=%0d want hit=%0d miss=%0d evict=%0d",
                     hit_cnt, miss_cnt, evict_cnt,
                     m_hits > CNT_MAX ? CNT_MAX : m_hits,
                     m_misses > CNT_MAX ? CNT_MAX : m_misses,
                     m_evicts > CNT_MAX ? CNT_MAX : m_evicts);
        end
`endif
        $display("txn idx=%0d h0=%0b h1=%0b hit=%0b way=%0b lat=%0d", idx, h0, h1, exp_hit, exp_way, got_lat);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (cpu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b want=1", cpu_ready);
        end
        vectors++;
        if ({cpu_done, cpu_hit, cpu_way, mem_req_valid, fill_we, fill_way} !== 6'b0 ||
            mem_req_index !== '0 || fill_index !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got done=%b hit=%b way=%b mreq=%b we=%b fway=%b midx=%0d fidx=%0d want all 0",
                     cpu_done, cpu_hit, cpu_way, mem_req_valid, fill_we, fill_way, mem_req_index, fill_index);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("txn reset released");
    endtask

    // Fill both ways of set 3, then walk the FIFO order; a hit must not disturb it.
    task automatic test_fifo_order();
        run_txn(3, 0, 0, 0, 0);   // cold miss -> way 0
        run_txn(3, 0, 0, 0, 0);   // -> way 1
        run_txn(3, 0, 0, 0, 0);   // evict way 0
        run_txn(3, 0, 0, 0, 0);   // evict way 1
        run_txn(3, 0, 1, 0, 0);   // hit in way 1
        run_txn(3, 0, 0, 0, 0);   // still evicts per pointer
    endtask

    task automatic test_backpressure();
        run_txn(5, 0, 0, 5, 7);
        run_txn(5, 1, 0, 0, 0);
    endtask

    task automatic test_both_hit();
        run_txn(7, 0, 0, 0, 0);
        run_txn(7, 0, 0, 1, 2);
        run_txn(7, 1, 1, 0, 0);   // both ways hit -> way 0
    endtask

    // Reset during REQ (in_wait=0) or WAIT (in_wait=1); a late response afterwards must do nothing.
    task automatic test_reset_mid(input bit in_wait);
        cpu_req_valid = 1'b1;
        cpu_index     = 3'd3;
        hit_way0      = 1'b0;
        hit_way1      = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        vectors++;
        if (mem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_req_start got=%b want=1", mem_req_valid);
        end
        if (in_wait) begin
            mem_req_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0 || cpu_ready !== 1'b1 || fill_we !== 1'b0 || cpu_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset wait=%0b got mreq=%b ready=%b we=%b done=%b want 0 1 0 0",
                     in_wait, mem_req_valid, cpu_ready, fill_we, cpu_done);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (fill_we !== 1'b0 || cpu_done !== 1'b0 || mem_req_valid !== 1'b0 || cpu_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stray_rsp cyc=%0d got we=%b done=%b mreq=%b ready=%b want 0 0 0 1",
                         i, fill_we, cpu_done, mem_req_valid, cpu_ready);
            end
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        $display("txn mid-sequence reset in_wait=%0b", in_wait);
        run_txn(3, 1, 1, 0, 0);   // valid bits were cleared: this is a miss into way 0
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            run_txn($urandom_range(0, SETS - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_hit_burst();
        run_txn(2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_txn(2, 1, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_backpressure();
        test_both_hit();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_hit_burst();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
